// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared memory map, target indices and FSM states for the data-side bus demux
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int TGT_A   = 0;
    localparam int TGT_B   = 1;
    localparam int TGT_C   = 2;
    localparam int NUM_TGT = 3;

    // Default memory map: 16 KB data RAM, 16 KB boot ROM, 4 KB peripheral block.
    localparam logic [31:0] DEF_TGT_A_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_TGT_A_MASK = 32'hFFFF_C000;
    localparam logic [31:0] DEF_TGT_B_BASE = 32'h0001_0000;
    localparam logic [31:0] DEF_TGT_B_MASK = 32'hFFFF_C000;
    localparam logic [31:0] DEF_TGT_C_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_TGT_C_MASK = 32'hFFFF_F000;

endpackage

// File: rtl/mem_addr_decode.sv
// rtl/mem_addr_decode.sv - combinational address decode to a one-hot target hit with A > B > C priority
module mem_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int                AWIDTH = 32,
    parameter logic [AWIDTH-1:0] A_BASE = AWIDTH'(DEF_TGT_A_BASE),
    parameter logic [AWIDTH-1:0] A_MASK = AWIDTH'(DEF_TGT_A_MASK),
    parameter logic [AWIDTH-1:0] B_BASE = AWIDTH'(DEF_TGT_B_BASE),
    parameter logic [AWIDTH-1:0] B_MASK = AWIDTH'(DEF_TGT_B_MASK),
    parameter logic [AWIDTH-1:0] C_BASE = AWIDTH'(DEF_TGT_C_BASE),
    parameter logic [AWIDTH-1:0] C_MASK = AWIDTH'(DEF_TGT_C_MASK)
) (
    input  logic [AWIDTH-1:0]  addr_i,
    output logic [NUM_TGT-1:0] hit_o,
    output logic               miss_o
);

    logic [NUM_TGT-1:0] raw_hit;

    always_comb begin
        raw_hit[TGT_A] = ((addr_i & A_MASK) == A_BASE);
        raw_hit[TGT_B] = ((addr_i & B_MASK) == B_BASE);
        raw_hit[TGT_C] = ((addr_i & C_MASK) == C_BASE);

        hit_o = '0;
        if (raw_hit[TGT_A]) begin
            hit_o[TGT_A] = 1'b1;
        end else if (raw_hit[TGT_B]) begin
            hit_o[TGT_B] = 1'b1;
        end else if (raw_hit[TGT_C]) begin
            hit_o[TGT_C] = 1'b1;
        end
        miss_o = ~|raw_hit;
    end

endmodule

// File: rtl/mem_bus_demux.sv
// rtl/mem_bus_demux.sv - routes one load/store to one of three targets and returns its response
// One transaction in flight; a target that stalls beyond TIMEOUT cycles gets an error response.
module mem_bus_demux
    import mem_bus_pkg::*;
#(
    parameter int                DWIDTH     = 32,
    parameter int                AWIDTH     = 32,
    parameter logic [AWIDTH-1:0] TGT_A_BASE = AWIDTH'(DEF_TGT_A_BASE),
    parameter logic [AWIDTH-1:0] TGT_A_MASK = AWIDTH'(DEF_TGT_A_MASK),
    parameter logic [AWIDTH-1:0] TGT_B_BASE = AWIDTH'(DEF_TGT_B_BASE),
    parameter logic [AWIDTH-1:0] TGT_B_MASK = AWIDTH'(DEF_TGT_B_MASK),
    parameter logic [AWIDTH-1:0] TGT_C_BASE = AWIDTH'(DEF_TGT_C_BASE),
    parameter logic [AWIDTH-1:0] TGT_C_MASK = AWIDTH'(DEF_TGT_C_MASK),
    parameter int                TIMEOUT    = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Req_Valid,
    output logic                        Req_Ready,
    input  logic [AWIDTH-1:0]           Req_Addr,
    input  logic                        Req_Wr,
    input  logic [DWIDTH-1:0]           Req_Wdata,
    input  logic [DWIDTH/8-1:0]         Req_Be,
    output logic                        Rsp_Valid,
    output logic [DWIDTH-1:0]           Rsp_Rdata,
    output logic                        Rsp_Err,
    output logic [NUM_TGT-1:0]          Tgt_Req_Valid,
    input  logic [NUM_TGT-1:0]          Tgt_Req_Ready,
    output logic [AWIDTH-1:0]           Tgt_Addr,
    output logic                        Tgt_Wr,
    output logic [DWIDTH-1:0]           Tgt_Wdata,
    output logic [DWIDTH/8-1:0]         Tgt_Be,
    input  logic [NUM_TGT-1:0]          Tgt_Rsp_Valid,
    input  logic [NUM_TGT*DWIDTH-1:0]   Tgt_Rsp_Rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state_q;
    logic [NUM_TGT-1:0]   sel_q;
    logic [AWIDTH-1:0]    addr_q;
    logic                 wr_q;
    logic [DWIDTH-1:0]    wdata_q;
    logic [DWIDTH/8-1:0]  be_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [DWIDTH-1:0]    rsp_rdata_q;

    logic [NUM_TGT-1:0]   dec_hit;
    logic                 dec_miss;
    logic                 sel_ready;
    logic                 sel_rsp;
    logic [DWIDTH-1:0]    sel_rdata;
    logic                 expired;

    mem_addr_decode #(
        .AWIDTH (AWIDTH),
        .A_BASE (TGT_A_BASE),
        .A_MASK (TGT_A_MASK),
        .B_BASE (TGT_B_BASE),
        .B_MASK (TGT_B_MASK),
        .C_BASE (TGT_C_BASE),
        .C_MASK (TGT_C_MASK)
    ) u_decode (
        .addr_i (Req_Addr),
        .hit_o  (dec_hit),
        .miss_o (dec_miss)
    );

    // Only the selected target's handshakes matter; the others are masked off by sel_q.
    always_comb begin
        sel_ready = |(Tgt_Req_Ready & sel_q);
        sel_rsp   = |(Tgt_Rsp_Valid & sel_q);
        sel_rdata = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | Tgt_Rsp_Rdata[k*DWIDTH +: DWIDTH];
            end
        end
        expired = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (Req_Valid) begin
                        addr_q  <= Req_Addr;
                        wr_q    <= Req_Wr;
                        wdata_q <= Req_Wdata;
                        be_q    <= Req_Be;
                        sel_q   <= dec_hit;
                        cnt_q   <= '0;
                        if (dec_miss) begin
                            state_q     <= ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sel_ready) begin
                        state_q <= WAIT;
                    end else if (expired) begin
                        state_q     <= ERR;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sel_rsp) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= wr_q ? '0 : sel_rdata;
                    end else if (expired) begin
                        state_q     <= ERR;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Req_Ready     = (state_q == IDLE);
    assign Tgt_Req_Valid = (state_q == REQ) ? sel_q : '0;
    assign Tgt_Addr      = addr_q;
    assign Tgt_Wr        = wr_q;
    assign Tgt_Wdata     = wdata_q;
    assign Tgt_Be        = be_q;
    assign Rsp_Valid     = rsp_valid_q;
    assign Rsp_Err       = rsp_err_q;
    assign Rsp_Rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_mem_bus_demux.sv
// tb/tb_mem_bus_demux.sv - directed bench with a transaction-level timing model of the bus demux
module tb_mem_bus_demux;

    localparam int T = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic [31:0] Req_Addr;
    logic        Req_Wr;
    logic [31:0] Req_Wdata;
    logic [3:0]  Req_Be;
    logic        Rsp_Valid;
    logic [31:0] Rsp_Rdata;
    logic        Rsp_Err;
    logic [2:0]  Tgt_Req_Valid;
    logic [2:0]  Tgt_Req_Ready;
    logic [31:0] Tgt_Addr;
    logic        Tgt_Wr;
    logic [31:0] Tgt_Wdata;
    logic [3:0]  Tgt_Be;
    logic [2:0]  Tgt_Rsp_Valid;
    logic [95:0] Tgt_Rsp_Rdata;

    mem_bus_demux #(.TIMEOUT(T)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Req_Valid     (Req_Valid),
        .Req_Ready     (Req_Ready),
        .Req_Addr      (Req_Addr),
        .Req_Wr        (Req_Wr),
        .Req_Wdata     (Req_Wdata),
        .Req_Be        (Req_Be),
        .Rsp_Valid     (Rsp_Valid),
        .Rsp_Rdata     (Rsp_Rdata),
        .Rsp_Err       (Rsp_Err),
        .Tgt_Req_Valid (Tgt_Req_Valid),
        .Tgt_Req_Ready (Tgt_Req_Ready),
        .Tgt_Addr      (Tgt_Addr),
        .Tgt_Wr        (Tgt_Wr),
        .Tgt_Wdata     (Tgt_Wdata),
        .Tgt_Be        (Tgt_Be),
        .Tgt_Rsp_Valid (Tgt_Rsp_Valid),
        .Tgt_Rsp_Rdata (Tgt_Rsp_Rdata)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Expected DUT behaviour per clock period, filled in when a request is issued.
    logic [2:0]  exp_tv    [int];
    bit          exp_busy  [int];
    bit          exp_rv    [int];
    bit          exp_err   [int];
    logic [31:0] exp_data  [int];
    logic [31:0] exp_addr  [int];
    logic        exp_wr    [int];
    logic [31:0] exp_wdata [int];
    logic [3:0]  exp_be    [int];

    // Scripted target-side inputs per clock period.
    logic [2:0]  drv_rdy [int];
    logic [2:0]  drv_rv  [int];
    logic [95:0] drv_dat [int];

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;
    int  last_rsp = -1;
    logic [31:0] last_rdata = '0;
    logic last_err = 1'b0;
    int  tv_cnt = 0;
    int  acc_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        logic [31:0] base [3];
        logic [31:0] mask [3];
        base[0] = 32'h0000_0000; mask[0] = 32'hFFFF_C000;
        base[1] = 32'h0001_0000; mask[1] = 32'hFFFF_C000;
        base[2] = 32'h8000_0000; mask[2] = 32'hFFFF_F000;
        for (int i = 0; i < 3; i++) begin
            if ((a & mask[i]) == base[i]) return i;
        end
        return -1;
    endfunction

    task automatic add_rv(input int per, input int k);
        logic [2:0] b;
        b = 3'b001 << k;
        drv_rv[per] = (drv_rv.exists(per) ? drv_rv[per] : 3'b000) | b;
    endtask

    task automatic put_dat(input int per, input int k, input logic [31:0] d);
        logic [95:0] t;
        t = drv_dat.exists(per) ? drv_dat[per] : 96'h0;
        t[k*32 +: 32] = d;
        drv_dat[per] = t;
    endtask

    always @(posedge Clk) begin
        #2;
        Tgt_Req_Ready = drv_rdy.exists(cyc) ? drv_rdy[cyc] : 3'b000;
        Tgt_Rsp_Valid = drv_rv.exists(cyc) ? drv_rv[cyc] : 3'b000;
        Tgt_Rsp_Rdata = drv_dat.exists(cyc) ? drv_dat[cyc] : 96'h0;
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(Req_Ready), exp_busy.exists(cyc) ? 64'd0 : 64'd1);
            chk("tgt_req_valid", 64'(Tgt_Req_Valid), exp_tv.exists(cyc) ? 64'(exp_tv[cyc]) : 64'd0);
            chk("rsp_valid", 64'(Rsp_Valid), exp_rv.exists(cyc) ? 64'd1 : 64'd0);
            if (exp_rv.exists(cyc)) begin
                chk("rsp_err", 64'(Rsp_Err), 64'(exp_err[cyc]));
                chk("rsp_rdata", 64'(Rsp_Rdata), 64'(exp_data[cyc]));
            end
            if (exp_tv.exists(cyc)) begin
                chk("tgt_addr", 64'(Tgt_Addr), 64'(exp_addr[cyc]));
                chk("tgt_wr", 64'(Tgt_Wr), 64'(exp_wr[cyc]));
                chk("tgt_wdata", 64'(Tgt_Wdata), 64'(exp_wdata[cyc]));
                chk("tgt_be", 64'(Tgt_Be), 64'(exp_be[cyc]));
            end
            if (Rsp_Valid) begin
                last_rsp   = cyc;
                last_rdata = Rsp_Rdata;
                last_err   = Rsp_Err;
            end
            if (Tgt_Req_Valid != 3'b000) tv_cnt++;
            if (Req_Valid && Req_Ready) acc_q.push_back(cyc);
        end
    end

    // rd: REQ cycles before the target is ready (>= T means never);
    // sd: WAIT cycles before the response (< 0 means never).
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] be, input int rd, input int sd,
                         input logic [31:0] rdat, output int rp);
        int p;
        int k;
        int nreq;
        bit err;
        logic [31:0] dexp;
        p = cyc;
        k = decode(a);
        err = 1'b1;
        dexp = 32'h0;
        Req_Valid = 1'b1;
        Req_Addr  = a;
        Req_Wr    = w;
        Req_Wdata = wd;
        Req_Be    = be;
        if (k < 0) begin
            rp = p + 1;
        end else begin
            nreq = (rd >= T) ? T : rd + 1;
            for (int i = 0; i < nreq; i++) begin
                exp_tv[p+1+i]    = 3'b001 << k;
                exp_addr[p+1+i]  = a;
                exp_wr[p+1+i]    = w;
                exp_wdata[p+1+i] = wd;
                exp_be[p+1+i]    = be;
            end
            if (rd < T) drv_rdy[p+1+rd] = 3'b001 << k;
            if (rd >= T || sd < 0 || rd + sd + 2 > T) begin
                rp = p + 1 + T;
            end else begin
                rp = p + 3 + rd + sd;
                add_rv(p + 2 + rd + sd, k);
                for (int j = 0; j < 3; j++) put_dat(p + 2 + rd + sd, j, ~rdat);
                put_dat(p + 2 + rd + sd, k, rdat);
                err  = 1'b0;
                dexp = w ? 32'h0 : rdat;
            end
        end
        for (int i = p + 1; i <= rp; i++) exp_busy[i] = 1'b1;
        exp_rv[rp]   = 1'b1;
        exp_err[rp]  = err;
        exp_data[rp] = dexp;
    endtask

    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] be, input int rd, input int sd,
                       input logic [31:0] rdat, input bit hold,
                       output int p_acc, output int rp);
        p_acc = cyc;
        issue(a, w, wd, be, rd, sd, rdat, rp);
        @(posedge Clk); #1;
        if (!hold) Req_Valid = 1'b0;
        while (cyc <= rp) begin
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int p, rp;
        Reset = 1'b1;
        Req_Valid = 1'b0; Req_Addr = '0; Req_Wr = 1'b0; Req_Wdata = '0; Req_Be = '0;
        Tgt_Req_Ready = '0; Tgt_Rsp_Valid = '0; Tgt_Rsp_Rdata = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_req_ready", 64'(Req_Ready), 64'd1);
        chk("rst_tgt_req_valid", 64'(Tgt_Req_Valid), 64'd0);
        chk("rst_rsp_valid", 64'(Rsp_Valid), 64'd0);
        chk("rst_rsp_err", 64'(Rsp_Err), 64'd0);
        chk("rst_rsp_rdata", 64'(Rsp_Rdata), 64'd0);
        chk("rst_tgt_addr", 64'(Tgt_Addr), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk_en = 1'b1;

        // Load from A, zero-wait target.
        tv_cnt = 0;
        txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, p, rp);
        chk("t1_latency", 64'(last_rsp - p), 64'd3);
        chk("t1_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
        chk("t1_err", 64'(last_err), 64'd0);
        chk("t1_tv_cycles", 64'(tv_cnt), 64'd1);

        // Store to C, ready after 2 cycles.
        tv_cnt = 0;
        txn(32'h8000_0004, 1'b1, 32'h1234_5678, 4'b0011, 2, 0, 32'hCAFE_F00D, 1'b0, p, rp);
        chk("t2_tv_cycles", 64'(tv_cnt), 64'd3);
        chk("t2_rdata", 64'(last_rdata), 64'd0);
        chk("t2_err", 64'(last_err), 64'd0);
        chk("t2_latency", 64'(last_rsp - p), 64'd5);

        // Decode miss.
        tv_cnt = 0;
        txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h1111_1111, 1'b0, p, rp);
        chk("t3_tv_cycles", 64'(tv_cnt), 64'd0);
        chk("t3_latency", 64'(last_rsp - p), 64'd1);
        chk("t3_err", 64'(last_err), 64'd1);

        // B never responds; stray A response during WAIT and a late B response in IDLE.
        add_rv(cyc + 3, 0);
        put_dat(cyc + 3, 0, 32'h5555_AAAA);
        add_rv(cyc + 18, 1);
        put_dat(cyc + 18, 1, 32'h6666_0000);
        txn(32'h0001_0000, 1'b0, 32'h0, 4'hF, 0, -1, 32'h0, 1'b0, p, rp);
        chk("t4_latency", 64'(last_rsp - p), 64'd17);
        chk("t4_err", 64'(last_err), 64'd1);
        chk("t4_rdata", 64'(last_rdata), 64'd0);

        // Reset in the middle of WAIT; the late C response lands in IDLE.
        p = cyc;
        issue(32'h8000_0100, 1'b0, 32'h0, 4'hF, 0, 5, 32'h7777_0000, rp);
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #3;
        chk_en = 1'b0;
        Reset = 1'b1;
        #1;
        chk("t5_req_ready", 64'(Req_Ready), 64'd1);
        chk("t5_tgt_req_valid", 64'(Tgt_Req_Valid), 64'd0);
        chk("t5_rsp_valid", 64'(Rsp_Valid), 64'd0);
        chk("t5_rsp_err", 64'(Rsp_Err), 64'd0);
        chk("t5_rsp_rdata", 64'(Rsp_Rdata), 64'd0);
        chk("t5_tgt_addr", 64'(Tgt_Addr), 64'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        exp_tv.delete(); exp_busy.delete(); exp_rv.delete(); exp_err.delete();
        exp_data.delete(); exp_addr.delete(); exp_wr.delete(); exp_wdata.delete(); exp_be.delete();
        @(posedge Clk); #1;
        chk_en = 1'b1;
        last_rsp = -1;
        while (cyc < p + 9) begin
            @(posedge Clk); #1;
        end
        chk("t5_no_rsp", 64'(last_rsp), 64'hFFFF_FFFF_FFFF_FFFF);
        txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1, 2, 32'h0BAD_CAFE, 1'b0, p, rp);
        chk("t5_after_latency", 64'(last_rsp - p), 64'd6);
        chk("t5_after_rdata", 64'(last_rdata), 64'h0BAD_CAFE);

        // Response in the last allowed cycle wins over the timeout.
        txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 3, 11, 32'h1357_9BDF, 1'b0, p, rp);
        chk("t6_tie_latency", 64'(last_rsp - p), 64'd17);
        chk("t6_tie_err", 64'(last_err), 64'd0);
        chk("t6_tie_rdata", 64'(last_rdata), 64'h1357_9BDF);

        // One cycle too late is a timeout.
        txn(32'h0000_0300, 1'b0, 32'h0, 4'hF, 3, 12, 32'h2468_ACE0, 1'b0, p, rp);
        chk("t6_late_err", 64'(last_err), 64'd1);

        // Target never ready: timeout out of REQ.
        tv_cnt = 0;
        txn(32'h0001_0040, 1'b1, 32'hA5A5_5A5A, 4'b1100, 20, 0, 32'h0, 1'b0, p, rp);
        chk("t6_req_to_tv_cycles", 64'(tv_cnt), 64'd16);
        chk("t6_req_to_latency", 64'(last_rsp - p), 64'd17);
        chk("t6_req_to_err", 64'(last_err), 64'd1);

        // Req_Valid held high: back-to-back acceptances.
        acc_q.delete();
        txn(32'h0000_0400, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0000_0001, 1'b1, p, rp);
        txn(32'h0001_0400, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0000_0002, 1'b1, p, rp);
        txn(32'h0000_0800, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0000_0003, 1'b0, p, rp);
        chk("b2b_count", 64'(acc_q.size()), 64'd3);
        for (int i = 1; i < acc_q.size(); i++) begin
            chk("b2b_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'd4);
        end
        chk("b2b_last_rdata", 64'(last_rdata), 64'h0000_0003);

        repeat (2) @(posedge Clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_demux.md
Name: mem_bus_demux

Overview:
- Routes one initiator's load/store request to one of three memory-mapped targets (data RAM, boot ROM, peripheral block), selected by address decode.
- Returns the selected target's response on a single response channel back to the initiator.
- Sits between the core's data-memory port and the target slaves. It is the distribution end of the datapath selection muxes: one source fanned out to many sinks.
- Sequential: one transaction outstanding at a time, valid/ready request handshake, bounded-latency timeout, decode-error response.

Parameters:
- DWIDTH, 32, data bus width.
- AWIDTH, 32, address width.
- TGT_A_BASE, 32'h0000_0000, target A base address.
- TGT_A_MASK, 32'hFFFF_C000, target A compare mask (16 KB).
- TGT_B_BASE, 32'h0001_0000, target B base address.
- TGT_B_MASK, 32'hFFFF_C000, target B compare mask.
- TGT_C_BASE, 32'h8000_0000, target C base address.
- TGT_C_MASK, 32'hFFFF_F000, target C compare mask (4 KB).
- TIMEOUT, 16, number of cycles allowed in REQ+WAIT before an error response is generated; must be at least 2.

Ports:
- Clk  in  1  clock; all flops rise on the positive edge.
- Reset  in  1  asynchronous, active-high reset.
- Req_Valid  in  1  initiator request valid.
- Req_Ready  out  1  block can accept a request.
- Req_Addr  in  AWIDTH  request byte address.
- Req_Wr  in  1  1 = store, 0 = load.
- Req_Wdata  in  DWIDTH  store data.
- Req_Be  in  DWIDTH/8  byte enables.
- Rsp_Valid  out  1  single-cycle response strobe.
- Rsp_Rdata  out  DWIDTH  load data; 0 for stores and errors.
- Rsp_Err  out  1  decode error or timeout.
- Tgt_Req_Valid  out  3  one-hot request valid; bit0 = A, bit1 = B, bit2 = C.
- Tgt_Req_Ready  in  3  per-target request ready.
- Tgt_Addr  out  AWIDTH  registered address, shared by all targets.
- Tgt_Wr  out  1  registered write flag, shared.
- Tgt_Wdata  out  DWIDTH  registered store data, shared.
- Tgt_Be  out  DWIDTH/8  registered byte enables, shared.
- Tgt_Rsp_Valid  in  3  per-target response valid.
- Tgt_Rsp_Rdata  in  3*DWIDTH  per-target read data; A = [DWIDTH-1:0], B next, C at the top.

Behaviour:
Interface:
- One clock domain, Clk.
- Reset is asynchronous and active-high.

Address decode:
- Target k is hit when (Req_Addr & TGT_k_MASK) == TGT_k_BASE.
- If regions overlap, priority is A > B > C.
- No hit is a decode error.

State machine — states IDLE, REQ, WAIT, RESP, ERR:
- IDLE
  - Req_Ready = 1; Req_Ready is combinational (state == IDLE).
  - When Req_Valid = 1: register Addr, Wr, Wdata, Be and the one-hot select.
  - Go to REQ on a hit, or ERR on a miss.
- REQ
  - Tgt_Req_Valid = registered select.
  - When Tgt_Req_Ready[sel] = 1: go to WAIT.
  - Tgt_Rsp_Valid is ignored in REQ.
- WAIT
  - Tgt_Req_Valid = 0.
  - When Tgt_Rsp_Valid[sel] = 1: capture Tgt_Rsp_Rdata slice sel (forced to 0 if Wr = 1), then go to RESP.
  - Responses from non-selected targets are ignored.
- RESP
  - Rsp_Valid = 1, Rsp_Err = 0, Rsp_Rdata = captured data, for exactly one cycle; then IDLE.
- ERR
  - Rsp_Valid = 1, Rsp_Err = 1, Rsp_Rdata = 0, for one cycle; then IDLE.

Timeout:
- Counter width is clog2(TIMEOUT). It clears on entry to REQ and increments every cycle in REQ and in WAIT.
- When count reaches TIMEOUT-1 and the exit condition for the current state is not met, go to ERR.
- If the exit condition and the timeout occur in the same cycle, the exit condition wins.

Latency:
- Ready, zero-wait target: accept edge → REQ → WAIT, with response in the same cycle as WAIT → RESP.
- Rsp_Valid is therefore high in the 3rd cycle after acceptance.
- Decode error: Rsp_Valid in the 1st cycle after acceptance.

Outputs:
- Rsp_Valid, Rsp_Rdata and Rsp_Err are registered.
- Tgt_Req_Valid is decoded from state plus the registered select.
- The initiator must always accept Rsp_Valid; there is no response backpressure.

Reset:
- State goes to IDLE. All registered outputs, select, data and counter go to 0.
- Tgt_Req_Valid = 0, Rsp_Valid = 0, Req_Ready = 1.
- Reset during REQ or WAIT abandons the transaction with no response; a late target response after reset is ignored in IDLE.

Back-to-back:
- A new request is accepted only in IDLE, so the minimum spacing between acceptances is 4 cycles (hit) or 2 cycles (error).

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encodings IDLE..ERR;
  - target index constants TGT_A = 0, TGT_B = 1, TGT_C = 2;
  - the default base/mask constants, so the core top and the targets agree on the memory map.
- One sub-module, mem_addr_decode: combinational address → 3-bit one-hot hit plus miss flag, applying priority. It is reusable by the instruction-side fetch path.

Test Plan:
1. Load to 0x0000_0010, target A ready immediately, A responds with 0xDEAD_BEEF in the first WAIT cycle → Tgt_Req_Valid = 3'b001 for 1 cycle; Rsp_Valid = 1, Rsp_Err = 0, Rsp_Rdata = 0xDEAD_BEEF 3 cycles after acceptance.
2. Store 0x1234_5678, Be = 4'b0011, to 0x8000_0004, C ready after 2 cycles → Tgt_Req_Valid = 3'b100 for 3 cycles; Tgt_Wdata = 0x1234_5678, Tgt_Be = 4'b0011; Rsp_Rdata = 0, Rsp_Err = 0.
3. Load from 0x4000_0000 (no region) → no Tgt_Req_Valid; Rsp_Valid = 1, Rsp_Err = 1, Rsp_Rdata = 0 one cycle after acceptance.
4. Load to B (0x0001_0000), B never responds, TIMEOUT = 16 → Rsp_Err = 1 after 16 cycles in REQ+WAIT; a B response arriving later is ignored. Also drive a response on A while B is selected and check it is ignored.
5. Reset asserted mid-WAIT → all outputs 0 and Req_Ready = 1 asynchronously; no Rsp_Valid; the next load to A completes normally.
6. Timeout/exit tie: response arrives exactly at count = TIMEOUT-1 → normal RESP with Rsp_Err = 0. Separately, hold Req_Valid continuously → Req_Ready low outside IDLE, acceptance spacing exactly 4 cycles.
